// File: rtl/divisor_arbitro.sv
// divisor_arbitro
//   Shares one sequential signed divider (Divisor_Algoritmico_duv) between
//   N_REQ requesters. Round-robin grant, one operation in flight, divide by
//   zero answered locally, and a watchdog that answers with a timeout flag
//   if the divider never raises Done.
//
// Ports
//   CLK, RST          clock (rising edge), synchronous active-high reset
//   req_valid/ready   per-requester request handshake (ready is one-hot)
//   req_num/req_den   packed operands, requester i at [i*tamanyo +: tamanyo]
//   rsp_valid         one-hot, one-cycle response strobe to the owner
//   rsp_coc/rsp_res   shared quotient/remainder bus, valid with rsp_valid
//   rsp_dz/rsp_to     divide-by-zero / timeout flags, valid with rsp_valid
//   busy              high whenever an operation is in progress
//   div_*             connection to the single divider instance
module divisor_arbitro #(
    parameter int tamanyo = 32,
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 128
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*tamanyo-1:0]   req_num,
    input  logic [N_REQ*tamanyo-1:0]   req_den,
    output logic [N_REQ-1:0]           rsp_valid,
    output logic [tamanyo-1:0]         rsp_coc,
    output logic [tamanyo-1:0]         rsp_res,
    output logic                       rsp_dz,
    output logic                       rsp_to,
    output logic                       busy,
    output logic                       div_start,
    output logic [tamanyo-1:0]         div_num,
    output logic [tamanyo-1:0]         div_den,
    input  logic [tamanyo-1:0]         div_coc,
    input  logic [tamanyo-1:0]         div_res,
    input  logic                       div_done
);

    localparam int TW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

    state_t             state, state_nxt;
    logic [TW-1:0]      last_grant, tag, win_idx;
    logic               win_found;
    logic [tamanyo-1:0] op_num, op_den, coc_q, res_q;
    logic [tamanyo-1:0] sel_num, sel_den;
    logic               dz_q, to_q;
    logic [WW-1:0]      wdog;
    logic               wd_expired;

    // Per-requester operand views
    logic [tamanyo-1:0] lane_num [N_REQ];
    logic [tamanyo-1:0] lane_den [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        assign lane_num[i] = req_num[i*tamanyo +: tamanyo];
        assign lane_den[i] = req_den[i*tamanyo +: tamanyo];
    end

    assign sel_num    = lane_num[win_idx];
    assign sel_den    = lane_den[win_idx];
    assign wd_expired = (wdog == WW'(TIMEOUT - 1));

    // Round-robin search starting just after the last served requester
    always_comb begin
        logic [TW-1:0] cand;
        cand      = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = TW'((int'(last_grant) + k) % N_REQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && win_found && !RST)
            req_ready[win_idx] = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_found) state_nxt = (sel_den == '0) ? RESP : LAUNCH;
            LAUNCH:  state_nxt = WAIT;
            // Done has priority over an expiring watchdog on the same cycle
            WAIT:    if (div_done || wd_expired) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            last_grant <= TW'(N_REQ - 1);
            tag        <= '0;
            op_num     <= '0;
            op_den     <= '0;
            coc_q      <= '0;
            res_q      <= '0;
            dz_q       <= 1'b0;
            to_q       <= 1'b0;
            wdog       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        op_num <= sel_num;
                        op_den <= sel_den;
                        tag    <= win_idx;
                        to_q   <= 1'b0;
                        // Zero divisor never reaches the divider
                        dz_q   <= (sel_den == '0);
                        coc_q  <= '1;
                        res_q  <= sel_num;
                    end
                end
                LAUNCH: wdog <= '0;
                WAIT: begin
                    wdog <= wdog + 1'b1;
                    if (div_done) begin
                        coc_q <= div_coc;
                        res_q <= div_res;
                    end else if (wd_expired) begin
                        to_q  <= 1'b1;
                        coc_q <= '0;
                        res_q <= '0;
                    end
                end
                RESP: last_grant <= tag;
                default: ;
            endcase
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (state == RESP)
            rsp_valid[tag] = 1'b1;
    end

    assign rsp_coc   = (state == RESP) ? coc_q : '0;
    assign rsp_res   = (state == RESP) ? res_q : '0;
    assign rsp_dz    = (state == RESP) & dz_q;
    assign rsp_to    = (state == RESP) & to_q;
    assign busy      = (state != IDLE);
    assign div_start = (state == LAUNCH);
    // Operands held stable for the whole divider run
    assign div_num   = (state == LAUNCH || state == WAIT) ? op_num : '0;
    assign div_den   = (state == LAUNCH || state == WAIT) ? op_den : '0;

endmodule

// File: doc/divisor_arbitro.md
Name: divisor_arbitro

Overview:
- Shares one Divisor_Algoritmico_duv sequential signed divider between N_REQ requesters.
- Round-robin arbitration; one operation in flight at a time.
- Divide-by-zero is short-circuited without launching the divider.
- A watchdog flags a divider that never completes.
- Sits between client blocks and the single divider instance. Drives its Start/Num/Den and consumes its Coc/Res/Done.

Parameters:
- tamanyo, 32, operand/result width in bits (two's complement), matches divider.
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT, 128, WAIT-state cycle limit before timeout response (must exceed 2*tamanyo+2).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request valid; held until accepted.
- req_ready  out  N_REQ  one-hot accept strobe.
- req_num  in  N_REQ*tamanyo  dividends, requester i at bits [i*tamanyo +: tamanyo].
- req_den  in  N_REQ*tamanyo  divisors, same packing.
- rsp_valid  out  N_REQ  one-hot, one-cycle response strobe to the owning requester.
- rsp_coc  out  tamanyo  quotient, shared bus.
- rsp_res  out  tamanyo  remainder, shared bus.
- rsp_dz  out  1  divide-by-zero flag, valid with rsp_valid.
- rsp_to  out  1  timeout flag, valid with rsp_valid.
- busy  out  1  high whenever state != IDLE.
- div_start  out  1  divider Start.
- div_num  out  tamanyo  divider Num.
- div_den  out  tamanyo  divider Den.
- div_coc  in  tamanyo  divider Coc.
- div_res  in  tamanyo  divider Res.
- div_done  in  1  divider Done.

Behaviour:
- Clocking and reset: one clock CLK; reset RST is synchronous, active-high. All state updates on the rising edge of CLK.
- Reset values: state=IDLE; all outputs 0; internal regs 0. last_grant=N_REQ-1, so requester 0 has priority first.
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - req_ready is combinational: one-hot of the winner, asserted only in IDLE when any req_valid is set.
  - Winner = first set req_valid searching last_grant+1, last_grant+2, … modulo N_REQ.
  - On the same edge: capture winner's num/den into op regs and its index into tag.
  - If captured den == 0: go to RESP with dz=1, coc = all ones, res = num.
  - Otherwise go to LAUNCH.
- LAUNCH:
  - div_start=1 for exactly one cycle.
  - div_num/div_den = op regs, held constant from LAUNCH until leaving WAIT.
  - Clear watchdog counter; go to WAIT.
- WAIT:
  - Watchdog increments each cycle.
  - If div_done=1: capture div_coc/div_res; go to RESP.
  - Else if watchdog == TIMEOUT-1: to=1, coc=res=0; go to RESP.
  - If div_done and the watchdog limit coincide, div_done wins (to=0).
  - Latency is not hard-coded: completion is detected only via div_done. Nominal divider latency is 2*tamanyo+2 cycles after the start edge.
- RESP:
  - rsp_valid[tag]=1 for one cycle; rsp_coc, rsp_res, rsp_dz, rsp_to valid that cycle.
  - Next cycle: all rsp_* return to 0.
  - No response backpressure: requester must sample on the strobe.
  - last_grant <= tag; go to IDLE.
- Signed results: taken from the divider as-is. Quotient sign = sign(num) XOR sign(den); remainder sign = sign(num).
- div_done outside WAIT is ignored (stale or spurious).
- Throughput:
  - New request accepted no earlier than the cycle after RESP.
  - Non-zero divisor op: accept edge, LAUNCH, WAIT, RESP.
  - Divide-by-zero op: accept edge, RESP (response one cycle after accept).
- req_valid dropped before acceptance: withdrawal allowed, no effect. Operand values are sampled only on the accept edge.
- Reset mid-operation:
  - Abandons the op; no response issued; state=IDLE the cycle after RST.
  - The divider's reset is tied to the same source (RSTa = ~RST at integration), so the divider is also idle.
- Watchdog width: clog2(TIMEOUT)+1 bits, no wrap.

Test Plan:
- Req 0 only, num=100, den=7 -> req_ready[0] one cycle, div_start one pulse, rsp_valid[0] with coc=14, res=2, dz=0, to=0; busy low afterwards.
- Req 2, num=-100, den=7 -> rsp_valid[2], coc=0xFFFFFFF2 (-14), res=0xFFFFFFFE (-2). Then num=100, den=-7 -> coc=-14, res=2.
- All four requesters valid from reset, held until served -> grant order 0,1,2,3. Then only 0 and 2 kept valid -> grants alternate 0,2,0,2; each rsp_valid routed to the correct index.
- Req 1, num=55, den=0 -> rsp_valid[1] one cycle after accept, dz=1, coc=0xFFFFFFFF, res=55; div_start never asserted.
- Divider model never asserts div_done -> after TIMEOUT WAIT cycles, rsp_valid with to=1, coc=res=0. A following request is then served normally. A late div_done in IDLE is ignored (no extra rsp_valid).
- RST asserted for one cycle during WAIT -> all outputs 0 and IDLE next cycle, no rsp_valid for the aborted op. A subsequent request 9/3 returns coc=3, res=0.
